// File: rtl/shield_ctrl.sv
// Shield pickup sequencer: icon visibility, pickup detection, frame-counted protection
// timer with end-of-life blink, and one-hit absorption.
module shield_ctrl #(
   parameter int unsigned XPOS           = 800,
   parameter int unsigned YPOS           = 16,
   parameter int unsigned PICKUP_SIZE    = 64,
   parameter int unsigned PLAYER_SIZE    = 64,
   parameter int unsigned ACTIVE_FRAMES  = 600,
   parameter int unsigned RESPAWN_FRAMES = 300,
   parameter int unsigned BLINK_FRAMES   = 120,
   parameter int unsigned BLINK_PERIOD   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_game,
   input  logic        vsync,
   input  logic [10:0] player_x,
   input  logic [10:0] player_y,
   input  logic        hit,
   output logic        shield_visible,
   output logic        was_shield_picked_up,
   output logic        shield_active,
   output logic        shield_blink,
   output logic        player_hit,
   output logic        hit_absorbed
);

   // state     | meaning
   // S_IDLE    | no game running, everything off, hits dropped
   // S_AVAIL   | pickup icon shown, waiting for player overlap
   // S_ACTIVE  | player protected, timer counting frames down
   // S_RESPAWN | shield consumed/expired, icon hidden until timer ends
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_AVAIL   = 2'd1;
   localparam logic [1:0] S_ACTIVE  = 2'd2;
   localparam logic [1:0] S_RESPAWN = 2'd3;

   localparam logic [11:0] X_LO     = 12'(XPOS);
   localparam logic [11:0] X_HI     = 12'(XPOS + PICKUP_SIZE);
   localparam logic [11:0] Y_LO     = 12'(YPOS);
   localparam logic [11:0] Y_HI     = 12'(YPOS + PICKUP_SIZE);
   localparam logic [11:0] PL_SIZE  = 12'(PLAYER_SIZE);
   localparam logic [15:0] ACT_LOAD = 16'(ACTIVE_FRAMES);
   localparam logic [15:0] RSP_LOAD = 16'(RESPAWN_FRAMES);
   localparam logic [15:0] BLK_WIN  = 16'(BLINK_FRAMES);
   localparam logic [15:0] BLK_PER  = 16'(BLINK_PERIOD);

   logic        r_vsync_q;
   logic [1:0]  r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_phase;
   logic        r_visible;
   logic        r_active;
   logic        r_blink;
   logic        r_player_hit;
   logic        r_hit_absorbed;

   logic        w_tick;
   logic [11:0] w_px_end;
   logic [11:0] w_py_end;
   logic        w_overlap;
   logic [1:0]  w_state_nxt;
   logic [15:0] w_cnt_nxt;
   logic [15:0] w_phase_nxt;
   logic        w_blink_nxt;
   logic        w_player_hit_nxt;
   logic        w_absorbed_nxt;

   assign w_tick = r_vsync_q & ~vsync;

   // 12-bit sums cannot wrap for 11-bit positions, so touching edges compare cleanly
   assign w_px_end  = {1'b0, player_x} + PL_SIZE;
   assign w_py_end  = {1'b0, player_y} + PL_SIZE;
   assign w_overlap = (w_px_end > X_LO) && ({1'b0, player_x} < X_HI) &&
                      (w_py_end > Y_LO) && ({1'b0, player_y} < Y_HI);

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_player_hit_nxt = 1'b0;
      w_absorbed_nxt   = 1'b0;
      if (!start_game) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_AVAIL;
               w_cnt_nxt   = 16'd0;
            end
            S_AVAIL: begin
               w_player_hit_nxt = hit;
               if (w_overlap) begin
                  w_state_nxt = S_ACTIVE;
                  w_cnt_nxt   = ACT_LOAD;
               end
            end
            S_ACTIVE: begin
               // a hit outranks the expiring tick: the shield still absorbs it
               if (hit) begin
                  w_absorbed_nxt = 1'b1;
                  w_state_nxt    = S_RESPAWN;
                  w_cnt_nxt      = RSP_LOAD;
               end else if (w_tick) begin
                  if (r_cnt <= 16'd1) begin
                     w_state_nxt = S_RESPAWN;
                     w_cnt_nxt   = RSP_LOAD;
                  end else begin
                     w_cnt_nxt = r_cnt - 16'd1;
                  end
               end
            end
            default: begin
               w_player_hit_nxt = hit;
               if (w_tick) begin
                  if (r_cnt <= 16'd1) begin
                     w_state_nxt = S_AVAIL;
                     w_cnt_nxt   = 16'd0;
                  end else begin
                     w_cnt_nxt = r_cnt - 16'd1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      w_blink_nxt = 1'b0;
      w_phase_nxt = 16'd0;
      if (w_state_nxt == S_ACTIVE) begin
         if (w_cnt_nxt > BLK_WIN) begin
            w_blink_nxt = 1'b1;
         end else if ((r_state != S_ACTIVE) || (r_cnt > BLK_WIN)) begin
            // first frame inside the blink window starts dark with a fresh phase
            w_blink_nxt = 1'b0;
         end else if (w_tick) begin
            if ((r_phase + 16'd1) >= BLK_PER) begin
               w_blink_nxt = ~r_blink;
            end else begin
               w_blink_nxt = r_blink;
               w_phase_nxt = r_phase + 16'd1;
            end
         end else begin
            w_blink_nxt = r_blink;
            w_phase_nxt = r_phase;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vsync_q      <= 1'b1;
         r_state        <= S_IDLE;
         r_cnt          <= 16'd0;
         r_phase        <= 16'd0;
         r_visible      <= 1'b0;
         r_active       <= 1'b0;
         r_blink        <= 1'b0;
         r_player_hit   <= 1'b0;
         r_hit_absorbed <= 1'b0;
      end else begin
         r_vsync_q      <= vsync;
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_phase        <= w_phase_nxt;
         r_visible      <= (w_state_nxt == S_AVAIL);
         r_active       <= (w_state_nxt == S_ACTIVE);
         r_blink        <= w_blink_nxt;
         r_player_hit   <= w_player_hit_nxt;
         r_hit_absorbed <= w_absorbed_nxt;
      end
   end

   assign shield_visible       = r_visible;
   assign was_shield_picked_up = r_active;
   assign shield_active        = r_active;
   assign shield_blink         = r_blink;
   assign player_hit           = r_player_hit;
   assign hit_absorbed         = r_hit_absorbed;

endmodule

// File: tb/tb_shield_ctrl.sv
// Bench for shield_ctrl: directed scenarios then random play, every cycle checked
// against a frame-level reference model.
module tb_shield_ctrl;

   localparam int AF = 4;
   localparam int RF = 2;
   localparam int BF = 2;
   localparam int BP = 1;
   localparam int FR = 12;

   localparam int M_IDLE = 0;
   localparam int M_AVAIL = 1;
   localparam int M_ACT = 2;
   localparam int M_RESP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_game = 1'b0;
   logic        vsync = 1'b1;
   logic [10:0] player_x = '0;
   logic [10:0] player_y = '0;
   logic        hit = 1'b0;
   logic        shield_visible, was_shield_picked_up, shield_active;
   logic        shield_blink, player_hit, hit_absorbed;

   shield_ctrl #(
      .XPOS(800), .YPOS(16), .PICKUP_SIZE(64), .PLAYER_SIZE(64),
      .ACTIVE_FRAMES(AF), .RESPAWN_FRAMES(RF), .BLINK_FRAMES(BF), .BLINK_PERIOD(BP)
   ) u_dut (
      .clk(clk), .rst(rst), .start_game(start_game), .vsync(vsync),
      .player_x(player_x), .player_y(player_y), .hit(hit),
      .shield_visible(shield_visible), .was_shield_picked_up(was_shield_picked_up),
      .shield_active(shield_active), .shield_blink(shield_blink),
      .player_hit(player_hit), .hit_absorbed(hit_absorbed)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;

   int m_mode, m_left;
   bit m_vprev;
   bit e_vis, e_act, e_blink, e_ph, e_ha;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t mode=%0d left=%0d)",
                  tag, obs, exp, $time, m_mode, m_left);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_left = 0; m_vprev = 1'b1;
      e_vis = 0; e_act = 0; e_blink = 0; e_ph = 0; e_ha = 0;
   endtask

   task automatic model_update(input bit sg, input bit vs, input int px, input int py, input bit h);
      bit tick, ov;
      tick = m_vprev && !vs;
      m_vprev = vs;
      ov = (px + 64 > 800) && (px < 864) && (py + 64 > 16) && (py < 80);
      e_ph = 0; e_ha = 0;
      if (!sg) begin
         m_mode = M_IDLE; m_left = 0;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_AVAIL;
      end else if (m_mode == M_AVAIL) begin
         e_ph = h;
         if (ov) begin m_mode = M_ACT; m_left = AF; end
      end else if (m_mode == M_ACT) begin
         if (h) begin
            e_ha = 1; m_mode = M_RESP; m_left = RF;
         end else if (tick) begin
            if (m_left == 1) begin m_mode = M_RESP; m_left = RF; end
            else m_left--;
         end
      end else begin
         e_ph = h;
         if (tick) begin
            if (m_left == 1) begin m_mode = M_AVAIL; m_left = 0; end
            else m_left--;
         end
      end
      e_vis = (m_mode == M_AVAIL);
      e_act = (m_mode == M_ACT);
      // inside the window: dark first, one toggle every BP frames
      if (m_mode != M_ACT) e_blink = 0;
      else if (m_left > BF) e_blink = 1;
      else e_blink = (((BF - m_left) / BP) % 2) == 1;
   endtask

   task automatic check_all();
      chk("visible", 16'(shield_visible), 16'(e_vis));
      chk("picked", 16'(was_shield_picked_up), 16'(e_act));
      chk("active", 16'(shield_active), 16'(e_act));
      chk("blink", 16'(shield_blink), 16'(e_blink));
      chk("player_hit", 16'(player_hit), 16'(e_ph));
      chk("hit_absorbed", 16'(hit_absorbed), 16'(e_ha));
   endtask

   task automatic step(input bit sg, input int px, input int py, input bit h);
      @(negedge clk);
      start_game = sg; player_x = 11'(px); player_y = 11'(py); hit = h;
      vsync = (cyc % FR) >= 2;
      cyc++;
      model_update(sg, vsync, px, py, h);
      @(posedge clk);
      #1;
      check_all();
   endtask

   function automatic bit next_tick();
      return m_vprev && !((cyc % FR) >= 2);
   endfunction

   task automatic wait_mode(input int mode, input string tag);
      int n = 0;
      while (m_mode != mode && n < 200) begin
         step(1, 0, 0, 0);
         n++;
      end
      if (m_mode != mode) begin
         n_tests++; n_fail++;
         $display("FAIL timeout_%s: mode %0d, required %0d", tag, m_mode, mode);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk({tag, "_async_vis"}, 16'(shield_visible), 16'd0);
      chk({tag, "_async_act"}, 16'(shield_active), 16'd0);
      vsync = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 check_all();
      #1 rst = 1'b0;
   endtask

   initial begin
      int xs[8] = '{0, 735, 736, 737, 780, 863, 864, 1000};
      int ys[7] = '{0, 15, 16, 40, 79, 80, 200};
      int cx, cy, n;
      bit sg;
      model_reset();
      #1 rst = 1'b1;
      @(posedge clk);
      #1 check_all();
      #1 rst = 1'b0;

      // icon appears one edge after start
      step(1, 0, 0, 0);
      chk("t1_visible", 16'(shield_visible), 16'd1);
      // pickup, expiry, respawn with blink pattern
      step(1, 780, 40, 0);
      chk("t2_active", 16'(shield_active), 16'd1);
      wait_mode(M_RESP, "t2_resp");
      wait_mode(M_AVAIL, "t2_avail");
      // absorbed hit after one tick
      step(1, 780, 40, 0);
      n = 0;
      while (m_left != AF - 1 && n < 100) begin step(1, 0, 0, 0); n++; end
      step(1, 0, 0, 1);
      chk("t4_absorbed", 16'(hit_absorbed), 16'd1);
      chk("t4_no_player_hit", 16'(player_hit), 16'd0);
      wait_mode(M_AVAIL, "t4_avail");
      step(1, 0, 0, 1);
      chk("t4_player_hit", 16'(player_hit), 16'd1);
      // touching edge is no overlap
      for (int i = 0; i < 5; i++) step(1, 736, 16, 0);
      chk("t5_edge_no_pickup", 16'(shield_active), 16'd0);
      // hit on the final tick
      step(1, 780, 40, 0);
      n = 0;
      while (!(m_mode == M_ACT && m_left == 1 && next_tick()) && n < 200) begin
         step(1, 0, 0, 0); n++;
      end
      step(1, 0, 0, 1);
      chk("t5_final_tick_absorb", 16'(hit_absorbed), 16'd1);
      // hit coincident with pickup
      wait_mode(M_AVAIL, "t5_avail");
      step(1, 780, 40, 1);
      chk("t5_hit_pickup_ph", 16'(player_hit), 16'd1);
      chk("t5_hit_pickup_act", 16'(shield_active), 16'd1);
      // game stop mid-active, restart, async reset mid-respawn
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("t6_stop_active", 16'(shield_active), 16'd0);
      step(1, 0, 0, 0);
      step(1, 780, 40, 0);
      wait_mode(M_RESP, "t6_resp");
      do_reset("t6");
      step(1, 0, 0, 0);
      chk("t6_restart_vis", 16'(shield_visible), 16'd1);

      // random play
      cx = 0; cy = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            cx = xs[$urandom_range(0, 7)];
            cy = ys[$urandom_range(0, 6)];
         end
         sg = ($urandom_range(0, 149) != 0);
         step(sg, cx, cy, $urandom_range(0, 11) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
